// File: rtl/ov7670_stream_gen.sv
// OV7670 pixel-bus source: generates vsync/href/data with camera frame and
// line timing and a selectable deterministic test pattern.
module ov7670_stream_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_BLANK     = 288,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BP_LINES  = 17,
  parameter int unsigned V_FP_LINES  = 10,
  parameter logic [7:0]  CHROMA_BYTE = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] const_val,
  output logic       vsync,
  output logic       href,
  output logic [7:0] data,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  localparam int unsigned LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned MAX_A    = (VSYNC_LINES > V_BP_LINES) ? VSYNC_LINES : V_BP_LINES;
  localparam int unsigned MAX_B    = (V_ACTIVE > V_FP_LINES) ? V_ACTIVE : V_FP_LINES;
  localparam int unsigned LINE_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int unsigned LW       = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBP,
    S_ACTIVE,
    S_VFP
  } state_t;

  // First non-empty phase of a frame; zero-length phases are skipped.
  localparam state_t FIRST = (VSYNC_LINES != 0) ? S_VSYNC :
                             (V_BP_LINES  != 0) ? S_VBP   :
                             (V_ACTIVE    != 0) ? S_ACTIVE : S_VFP;

  // Next non-empty phase after s; S_IDLE means the frame has ended.
  function automatic state_t after(input state_t s);
    state_t r;
    r = S_IDLE;
    case (s)
      S_VSYNC:  r = (V_BP_LINES != 0) ? S_VBP :
                    (V_ACTIVE   != 0) ? S_ACTIVE :
                    (V_FP_LINES != 0) ? S_VFP : S_IDLE;
      S_VBP:    r = (V_ACTIVE   != 0) ? S_ACTIVE :
                    (V_FP_LINES != 0) ? S_VFP : S_IDLE;
      S_ACTIVE: r = (V_FP_LINES != 0) ? S_VFP : S_IDLE;
      default:  r = S_IDLE;
    endcase
    return r;
  endfunction

  function automatic int unsigned lines_of(input state_t s);
    int unsigned n;
    n = 0;
    case (s)
      S_VSYNC:  n = VSYNC_LINES;
      S_VBP:    n = V_BP_LINES;
      S_ACTIVE: n = V_ACTIVE;
      S_VFP:    n = V_FP_LINES;
      default:  n = 0;
    endcase
    return n;
  endfunction

  state_t          state, state_n;
  logic [CW-1:0]   col, col_n;
  logic [LW-1:0]   line, line_n;
  logic            pend, pend_n;
  logic [1:0]      mode_q, mode_n;
  logic [7:0]      cval_q, cval_n;
  logic            done_n;
  logic [7:0]      cnt_n;
  logic            go;
  logic            begin_frame;
  logic [7:0]      xb, yb, luma;
  logic            vsync_n, href_n, busy_n;
  logic [7:0]      data_n;

  // Next-state, counters, pending-start bookkeeping and next output values.
  // Outputs are computed from the next state so they register on the same
  // edge as the state change.
  always_comb begin
    state_n     = state;
    col_n       = col;
    line_n      = line;
    pend_n      = pend | start;
    mode_n      = mode_q;
    cval_n      = cval_q;
    done_n      = 1'b0;
    cnt_n       = frame_count;
    go          = en | pend | start;
    begin_frame = 1'b0;

    if (state == S_IDLE) begin
      begin_frame = go;
    end else if (col == CW'(LINE_LEN - 1)) begin
      col_n = '0;
      if (line == LW'(lines_of(state) - 1)) begin
        line_n = '0;
        if (after(state) == S_IDLE) begin
          done_n = 1'b1;
          cnt_n  = frame_count + 8'd1;
          if (go) begin
            begin_frame = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          state_n = after(state);
        end
      end else begin
        line_n = line + LW'(1);
      end
    end else begin
      col_n = col + CW'(1);
    end

    if (begin_frame) begin
      state_n = FIRST;
      col_n   = '0;
      line_n  = '0;
      pend_n  = 1'b0;
      mode_n  = mode;
      cval_n  = const_val;
    end

    xb = 8'(col_n >> 1);
    yb = 8'(line_n);
    case (mode_n)
      2'd0:    luma = cval_n;
      2'd1:    luma = xb;
      2'd2:    luma = yb;
      default: luma = (xb[3] ^ yb[3]) ? 8'hFF : 8'h00;
    endcase

    vsync_n = (state_n == S_VSYNC);
    href_n  = (state_n == S_ACTIVE) && (32'(col_n) < 2 * H_ACTIVE);
    data_n  = href_n ? (col_n[0] ? CHROMA_BYTE : luma) : '0;
    busy_n  = (state_n != S_IDLE);
  end

  // State, counters, latched frame settings and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      col         <= '0;
      line        <= '0;
      pend        <= 1'b0;
      mode_q      <= '0;
      cval_q      <= '0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      data        <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      col         <= col_n;
      line        <= line_n;
      pend        <= pend_n;
      mode_q      <= mode_n;
      cval_q      <= cval_n;
      vsync       <= vsync_n;
      href        <= href_n;
      data        <= data_n;
      busy        <= busy_n;
      frame_done  <= done_n;
      frame_count <= cnt_n;
    end
  end

endmodule
